// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared constants and helpers for the VGA raster timing generator.
//   DEF_*          default 640x480@60 geometry (pixels / lines)
//   h_total()      pixels per line from active + porches + sync
//   v_total()      lines per frame from active + porches + sync
//   timing_state_e generator state (IDLE, RUN)
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;

   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } timing_state_e;

   function automatic int h_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int v_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_lock_sync.sv
// vga_lock_sync
// Two-flop synchronizer bringing the PLL lock indication into the pixel
// clock domain. Both flops clear on the synchronous reset.
//   clk  pixel clock
//   rst  synchronous reset, active-high
//   d    asynchronous input (PLL locked)
//   q    synchronized output, two cycles behind d
module vga_lock_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// 640x480@60 VGA raster timing from the 25 MHz PLL pixel clock, gated by
// PLL lock. Line/frame order is active, front porch, sync, back porch.
// All outputs are registered and lag the (h, v) counters by one cycle.
//
// Ports:
//   clk      pixel clock (PLL output)
//   rst      synchronous reset, active-high, priority over lock
//   locked   PLL lock indication
//   hsync_n  horizontal sync, active-low
//   vsync_n  vertical sync, active-low (whole lines)
//   active   visible pixel strobe
//   px_x     column, 0 outside the visible area
//   px_y     line, 0 outside the visible area
//   sof      pulse on pixel (0,0) of each frame
//   eol      pulse on the last visible pixel of each visible line
//   running  generator enabled (registered lock-qualified enable)
//
// Build option:
//   VGA_TIMING_LOCK_SYNC_EN  when defined, locked passes through a 2-flop
//                            synchronizer (2 extra cycles on rise and fall).
//                            Otherwise locked is used directly.
//
// state | meaning
// IDLE  | enable low or reset; counters held at (0,0), outputs at reset values
// RUN   | enable high; raster counting, outputs decoded from (h, v)
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter  int H_ACTIVE = DEF_H_ACTIVE,
   parameter  int H_FP     = DEF_H_FP,
   parameter  int H_SYNC   = DEF_H_SYNC,
   parameter  int H_BP     = DEF_H_BP,
   parameter  int V_ACTIVE = DEF_V_ACTIVE,
   parameter  int V_FP     = DEF_V_FP,
   parameter  int V_SYNC   = DEF_V_SYNC,
   parameter  int V_BP     = DEF_V_BP,
   localparam int H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
   localparam int V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
   localparam int HW       = $clog2(H_TOTAL),
   localparam int VW       = $clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          locked,
   output logic          hsync_n,
   output logic          vsync_n,
   output logic          active,
   output logic [HW-1:0] px_x,
   output logic [VW-1:0] px_y,
   output logic          sof,
   output logic          eol,
   output logic          running
);

   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);

   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic          en;
   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          vis;
   logic          in_hs;
   logic          in_vs;

   timing_state_e state;

`ifdef VGA_TIMING_LOCK_SYNC_EN
   vga_lock_sync u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (locked),
      .q   (en)
   );
`else
   assign en = locked;
`endif

   assign vis   = (h < H_ACT) && (v < V_ACT);
   assign in_hs = (h >= HS_BEG) && (h < HS_END);
   assign in_vs = (v >= VS_BEG) && (v < VS_END);

   // Counters sit at (0,0) whenever the generator is idle, so the first
   // enabled cycle always decodes pixel (0,0) and the next edge raises sof.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         state   <= IDLE;
         h       <= '0;
         v       <= '0;
         hsync_n <= 1'b1;
         vsync_n <= 1'b1;
         active  <= 1'b0;
         px_x    <= '0;
         px_y    <= '0;
         sof     <= 1'b0;
         eol     <= 1'b0;
      end else begin
         state   <= RUN;
         hsync_n <= !in_hs;
         vsync_n <= !in_vs;
         active  <= vis;
         px_x    <= vis ? h : '0;
         px_y    <= vis ? v : '0;
         sof     <= (h == '0) && (v == '0);
         eol     <= (h == H_LAST) && (v < V_ACT);
         if (h == H_MAX) begin
            h <= '0;
            v <= (v == V_MAX) ? '0 : v + 1'b1;
         end else begin
            h <= h + 1'b1;
         end
      end
   end

   // state only ever follows the registered enable, so it is the running flag.
   assign running = (state == RUN);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Scoreboard bench for vga_timing_gen. Full 800-pixel lines, frame height
// shortened to 15 lines so several frames fit in a short run.
module tb_vga_timing_gen;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 8;
   localparam int V_FP     = 2;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 3;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW       = $clog2(H_TOTAL);
   localparam int VW       = $clog2(V_TOTAL);
   localparam int FRAME    = H_TOTAL * V_TOTAL;
   localparam int HS_BEG   = H_ACTIVE + H_FP;
   localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_BEG   = V_ACTIVE + V_FP;
   localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
`ifdef VGA_TIMING_LOCK_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          locked;
   logic          hsync_n;
   logic          vsync_n;
   logic          active;
   logic [HW-1:0] px_x;
   logic [VW-1:0] px_y;
   logic          sof;
   logic          eol;
   logic          running;

   always #20 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .locked  (locked),
      .hsync_n (hsync_n),
      .vsync_n (vsync_n),
      .active  (active),
      .px_x    (px_x),
      .px_y    (px_y),
      .sof     (sof),
      .eol     (eol),
      .running (running)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] sb_q[$];

   // reference raster state
   int   mh = 0;
   int   mv = 0;
   logic ms1 = 1'b0;
   logic ms2 = 1'b0;

   // observed-output trackers
   int   cyc      = 0;
   int   last_sof = 0;
   int   last_eol = 0;
   int   act_cnt  = 0;
   int   hs_run   = 0;
   int   vs_run   = 0;
   logic frame_ok = 1'b0;
   logic eol_ok   = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pack(input logic hs, input logic vs, input logic act,
                                        input logic sf, input logic el, input logic rn,
                                        input logic [HW-1:0] x, input logic [VW-1:0] y);
      return 32'({hs, vs, act, sf, el, rn, x, y});
   endfunction

   function automatic logic [31:0] obs();
      return pack(hsync_n, vsync_n, active, sof, eol, running, px_x, px_y);
   endfunction

   function automatic logic [31:0] rst_vals();
      return pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
   endfunction

   task automatic track();
      cyc++;
      if (!running) begin
         frame_ok = 1'b0;
         eol_ok   = 1'b0;
         act_cnt  = 0;
         hs_run   = 0;
         vs_run   = 0;
      end else begin
         if (sof) begin
            if (frame_ok) begin
               check_val("sof_period", cyc - last_sof, FRAME);
               check_val("active_per_frame", act_cnt, H_ACTIVE * V_ACTIVE);
            end
            frame_ok = 1'b1;
            last_sof = cyc;
            act_cnt  = 0;
         end
         if (active) act_cnt++;
         if (eol) begin
            check_val("eol_x", 32'(px_x), H_ACTIVE - 1);
            if (eol_ok && px_y != '0) check_val("line_period", cyc - last_eol, H_TOTAL);
            eol_ok   = 1'b1;
            last_eol = cyc;
         end
         if (!hsync_n) hs_run++;
         else if (hs_run > 0) begin
            check_val("hsync_width", hs_run, H_SYNC);
            hs_run = 0;
         end
         if (!vsync_n) vs_run++;
         else if (vs_run > 0) begin
            check_val("vsync_width", vs_run, V_SYNC * H_TOTAL);
            vs_run = 0;
         end
      end
   endtask

   // One clock: compare last edge's outputs, apply new inputs, predict next edge.
   task automatic step(input logic r, input logic l);
      logic        men;
      logic        vis;
      logic [31:0] exp;
      @(negedge clk);
      if (sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         check_val("outputs", obs(), exp);
      end
      track();
      rst    = r;
      locked = l;
`ifdef VGA_TIMING_LOCK_SYNC_EN
      men = ms2;
      if (r) begin
         ms1 = 1'b0;
         ms2 = 1'b0;
      end else begin
         ms2 = ms1;
         ms1 = l;
      end
`else
      men = l;
`endif
      if (r || !men) begin
         sb_q.push_back(rst_vals());
         mh = 0;
         mv = 0;
      end else begin
         vis = (mh < H_ACTIVE) && (mv < V_ACTIVE);
         sb_q.push_back(pack(!(mh >= HS_BEG && mh < HS_END),
                             !(mv >= VS_BEG && mv < VS_END),
                             vis,
                             (mh == 0) && (mv == 0),
                             (mh == H_ACTIVE - 1) && (mv < V_ACTIVE),
                             1'b1,
                             vis ? HW'(mh) : '0,
                             vis ? VW'(mv) : '0));
         mh++;
         if (mh == H_TOTAL) begin
            mh = 0;
            mv++;
            if (mv == V_TOTAL) mv = 0;
         end
      end
   endtask

   initial begin
      int   n;
      logic found;
      rst    = 1'b1;
      locked = 1'b1;

      repeat (10) step(1'b1, 1'b1);
      check_val("reset_state", obs(), rst_vals());

      // release reset: sof latency from the first enabled cycle
      step(1'b0, 1'b1);
      n = 0;
      do begin
         step(1'b0, 1'b1);
         n++;
      end while (!sof && n < 20);
      check_val("sof_latency", n, LAT);
      check_val("first_pixel", 32'({active, px_x, px_y}), 32'({1'b1, HW'(0), VW'(0)}));

      // two full frames plus a margin for the sof period checks
      repeat (2 * FRAME + 50) step(1'b0, 1'b1);

      // mid-frame lock loss at line 5, pixel 300
      found = 1'b0;
      n = 0;
      while (!found && n < 2 * FRAME) begin
         step(1'b0, 1'b1);
         n++;
         found = active && (px_x == HW'(300)) && (px_y == VW'(5));
      end
      check_val("seek_pos", 32'(found), 1);
      step(1'b0, 1'b0);
      n = 0;
      do begin
         step(1'b0, 1'b0);
         n++;
      end while (running && n < 20);
      check_val("drop_latency", n, LAT);
      check_val("drop_state", obs(), rst_vals());
      repeat (5) step(1'b0, 1'b0);

      // relock restarts at (0,0)
      step(1'b0, 1'b1);
      n = 0;
      do begin
         step(1'b0, 1'b1);
         n++;
      end while (!sof && n < 20);
      check_val("relock_sof_latency", n, LAT);
      check_val("relock_pixel", 32'({px_x, px_y}), 0);

      // reset mid-line overrides lock
      repeat (H_TOTAL + 123) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check_val("rst_midframe", obs(), rst_vals());

      // restart and run past one complete frame
      repeat (FRAME + 2 * H_TOTAL) step(1'b0, 1'b1);
      step(1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
